// File: rtl/vram_arbiter_if.sv
// -----------------------------------------------------------------------------
// vram_arbiter_if
//   Bundles the video fetch port and the CPU request/acknowledge port of the
//   VRAM arbiter.
//
//   Video side : vid_strobe, vid_addr  -> vid_data, vid_color
//   CPU side   : cpu_req, cpu_we, cpu_addr, cpu_din -> cpu_dout, cpu_ack
//
//   Modports
//     master : the requesters (video generator + Z80 bus decode)
//     slave  : the arbiter that owns the two RAMs
// -----------------------------------------------------------------------------
interface vram_arbiter_if #(
    parameter int AW = 10
);
    // video fetch port
    logic          vid_strobe;
    logic [AW-1:0] vid_addr;
    logic [7:0]    vid_data;
    logic [7:0]    vid_color;

    // CPU port; cpu_addr[AW] selects the colour RAM
    logic          cpu_req;
    logic          cpu_we;
    logic [AW:0]   cpu_addr;
    logic [7:0]    cpu_din;
    logic [7:0]    cpu_dout;
    logic          cpu_ack;

    modport master (
        output vid_strobe,
        output vid_addr,
        input  vid_data,
        input  vid_color,
        output cpu_req,
        output cpu_we,
        output cpu_addr,
        output cpu_din,
        input  cpu_dout,
        input  cpu_ack
    );

    modport slave (
        input  vid_strobe,
        input  vid_addr,
        output vid_data,
        output vid_color,
        input  cpu_req,
        input  cpu_we,
        input  cpu_addr,
        input  cpu_din,
        output cpu_dout,
        output cpu_ack
    );
endinterface

// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
//   Owns the character RAM and the colour RAM (2**AW x 8 each, single port,
//   registered read) and shares them between the video fetch port, which is
//   never stalled, and the CPU req/ack port. After reset a clear engine fills
//   both RAMs with CLR_CHAR / CLR_COLOR before the CPU is served.
//
//   Per-cycle priority on the RAMs: video > clear > CPU.
//
//   Ports
//     clk_sys   in   system clock, all logic on posedge
//     reset_n   in   asynchronous active-low reset
//     bus       slave modport of vram_arbiter_if (video + CPU ports)
//     clr_busy  out  high while the clear engine is running
//
//   Timing
//     video : strobe in cycle N -> vid_data/vid_color valid from N+1, held
//             until the cycle after the next strobe
//     CPU   : access performed in the first IDLE/WAIT cycle without a video
//             strobe; cpu_ack pulses in the following cycle with cpu_dout
//             valid, cpu_dout then holds
// -----------------------------------------------------------------------------
module vram_arbiter #(
    parameter int         AW        = 10,
    parameter logic [7:0] CLR_CHAR  = 8'h20,
    parameter logic [7:0] CLR_COLOR = 8'h70
) (
    input  logic            clk_sys,
    input  logic            reset_n,
    vram_arbiter_if.slave   bus,
    output logic            clr_busy
);
    localparam int          DEPTH   = 1 << AW;
    localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

    // RAM index 0 = character RAM, 1 = colour RAM
    localparam int RAM_CHAR  = 0;
    localparam int RAM_COLOR = 1;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    state_t        state_reg;
    state_t        state_next;

    // One extra bit: the MSB flags that every location has been written.
    logic [AW:0]   clr_cnt_reg;
    logic [AW:0]   clr_cnt_next;

    // Shared single-port RAM controls (one address feeds both arrays)
    logic [AW-1:0] ram_addr;
    logic [1:0]    ram_we;
    logic [7:0]    ram_wd [0:1];
    logic [7:0]    ram_q  [0:1];

    // CPU access bookkeeping, captured in the cycle the access is performed
    logic          cpu_go;
    logic          acc_we_reg;
    logic          acc_sel_reg;
    logic [7:0]    acc_wdata_reg;
    logic [7:0]    cpu_dout_hold_reg;
    logic [7:0]    ack_data;

    // Video read pipeline: pend marks that ram_q holds a fresh video read
    logic          vid_pend_reg;
    logic [7:0]    vid_data_hold_reg;
    logic [7:0]    vid_color_hold_reg;

    // -------------------------------------------------------------------------
    // Storage: one inferred single-port RAM per array, read-first, with the
    // read data registered. The RAM content itself is never reset.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ram
            logic [7:0] mem [0:DEPTH-1];
            logic [7:0] q_reg;

            always_ff @(posedge clk_sys) begin
                if (ram_we[gi]) begin
                    mem[ram_addr] <= ram_wd[gi];
                end
                q_reg <= mem[ram_addr];
            end

            assign ram_q[gi] = q_reg;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // State register and side registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_reg          <= ST_CLEAR;
            clr_cnt_reg        <= '0;
            vid_pend_reg       <= 1'b0;
            vid_data_hold_reg  <= 8'h00;
            vid_color_hold_reg <= 8'h00;
            acc_we_reg         <= 1'b0;
            acc_sel_reg        <= 1'b0;
            acc_wdata_reg      <= 8'h00;
            cpu_dout_hold_reg  <= 8'h00;
        end else begin
            state_reg   <= state_next;
            clr_cnt_reg <= clr_cnt_next;

            // ram_q carries the strobed read for exactly one cycle; copy it
            // into the hold registers so the outputs survive later accesses.
            vid_pend_reg <= bus.vid_strobe;
            if (vid_pend_reg) begin
                vid_data_hold_reg  <= ram_q[RAM_CHAR];
                vid_color_hold_reg <= ram_q[RAM_COLOR];
            end

            if (cpu_go) begin
                acc_we_reg    <= bus.cpu_we;
                acc_sel_reg   <= bus.cpu_addr[AW];
                acc_wdata_reg <= bus.cpu_din;
            end

            if (state_reg == ST_ACK) begin
                cpu_dout_hold_reg <= ack_data;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and RAM port arbitration
    // -------------------------------------------------------------------------
    always_comb begin
        state_next          = state_reg;
        clr_cnt_next        = clr_cnt_reg;
        cpu_go              = 1'b0;
        ram_addr            = bus.vid_addr;
        ram_we              = 2'b00;
        ram_wd[RAM_CHAR]    = CLR_CHAR;
        ram_wd[RAM_COLOR]   = CLR_COLOR;

        unique case (state_reg)
            ST_CLEAR: begin
                // A video strobe steals the cycle; the clear simply waits.
                if (!bus.vid_strobe) begin
                    ram_addr     = clr_cnt_reg[AW-1:0];
                    ram_we       = 2'b11;
                    clr_cnt_next = clr_cnt_reg + CNT_ONE;
                    if (clr_cnt_next[AW]) begin
                        state_next = ST_IDLE;
                    end
                end
            end

            ST_IDLE, ST_WAIT: begin
                if (bus.cpu_req) begin
                    if (bus.vid_strobe) begin
                        state_next = ST_WAIT;
                    end else begin
                        cpu_go            = 1'b1;
                        ram_addr          = bus.cpu_addr[AW-1:0];
                        ram_wd[RAM_CHAR]  = bus.cpu_din;
                        ram_wd[RAM_COLOR] = bus.cpu_din;
                        if (bus.cpu_we) begin
                            ram_we = bus.cpu_addr[AW] ? 2'b10 : 2'b01;
                        end
                        state_next = ST_ACK;
                    end
                end else begin
                    state_next = ST_IDLE;
                end
            end

            ST_ACK: begin
                // cpu_req is not looked at here: one access per ack.
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_CLEAR;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // In ACK, ram_q holds the read issued by the access cycle; for a write the
    // written byte is returned instead.
    always_comb begin
        ack_data = acc_sel_reg ? ram_q[RAM_COLOR] : ram_q[RAM_CHAR];
        if (acc_we_reg) begin
            ack_data = acc_wdata_reg;
        end
    end

    assign bus.cpu_ack   = (state_reg == ST_ACK);
    assign bus.cpu_dout  = (state_reg == ST_ACK) ? ack_data : cpu_dout_hold_reg;
    assign bus.vid_data  = vid_pend_reg ? ram_q[RAM_CHAR]  : vid_data_hold_reg;
    assign bus.vid_color = vid_pend_reg ? ram_q[RAM_COLOR] : vid_color_hold_reg;
    assign clr_busy      = (state_reg == ST_CLEAR);

endmodule

// File: tb/tb_vram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vram_arbiter
//   Self-checking bench for vram_arbiter: a table of fixed transactions, hand
//   sequences for collisions / clear timing / reset, and random transactions
//   checked against a plain array model of both RAMs.
// -----------------------------------------------------------------------------
module tb_vram_arbiter;
    logic clk_sys = 1'b0;
    logic reset_n;
    logic clr_busy;

    always #5 clk_sys = ~clk_sys;

    vram_arbiter_if #(.AW(10)) bus ();

    vram_arbiter #(
        .AW       (10),
        .CLR_CHAR (8'h20),
        .CLR_COLOR(8'h70)
    ) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .bus     (bus),
        .clr_busy(clr_busy)
    );

    int total = 0;
    int bad   = 0;

    // Reference contents of the two RAMs
    logic [7:0] char_m  [0:1023];
    logic [7:0] color_m [0:1023];

    typedef struct {
        bit          is_cpu;
        bit          we;
        logic [10:0] addr;
        logic [7:0]  din;
        logic [7:0]  exp_a;   // vid_data or cpu_dout
        logic [7:0]  exp_b;   // vid_color (video rows only)
    } vec_t;

    vec_t vecs [0:10];

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b expected %0b", nm, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Strobe one video address and return what appears one cycle later.
    task automatic vid_read(input logic [9:0] a, output logic [7:0] d, output logic [7:0] c);
        bus.vid_strobe = 1'b1;
        bus.vid_addr   = a;
        tick();
        bus.vid_strobe = 1'b0;
        d = bus.vid_data;
        c = bus.vid_color;
    endtask

    // One CPU access; optionally collides with a video strobe in the first
    // cycle. lat = cycles from request to the ack sample, -1 on timeout.
    task automatic cpu_access(input logic we, input logic [10:0] a, input logic [7:0] din,
                              input bit collide, input logic [9:0] va,
                              output logic [7:0] dout, output int lat,
                              output logic [7:0] vd, output logic [7:0] vc);
        bit got;
        got  = 1'b0;
        lat  = 0;
        dout = 8'h00;
        vd   = 8'h00;
        vc   = 8'h00;
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = we;
        bus.cpu_addr = a;
        bus.cpu_din  = din;
        if (collide) begin
            bus.vid_strobe = 1'b1;
            bus.vid_addr   = va;
        end
        while (!got && lat < 20) begin
            tick();
            lat++;
            if (collide && lat == 1) begin
                vd = bus.vid_data;
                vc = bus.vid_color;
                bus.vid_strobe = 1'b0;
            end
            if (bus.cpu_ack === 1'b1) begin
                got  = 1'b1;
                dout = bus.cpu_dout;
            end
        end
        bus.cpu_req    = 1'b0;
        bus.vid_strobe = 1'b0;
        if (!got) lat = -1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  d, c, vd, vc, dout, exp_d, exp_vd, exp_vc;
        logic [31:0] r, r2;
        logic [9:0]  a, va;
        logic [10:0] ca;
        int          n, s, lat, acks, errs, first_bad;
        bit          collide;

        reset_n        = 1'b0;
        bus.vid_strobe = 1'b0;
        bus.vid_addr   = '0;
        bus.cpu_req    = 1'b0;
        bus.cpu_we     = 1'b0;
        bus.cpu_addr   = '0;
        bus.cpu_din    = '0;

        //               cpu   we    addr     din    exp_a  exp_b
        vecs[0]  = '{1'b0, 1'b0, 11'h000, 8'h00, 8'h20, 8'h70};
        vecs[1]  = '{1'b0, 1'b0, 11'h200, 8'h00, 8'h20, 8'h70};
        vecs[2]  = '{1'b0, 1'b0, 11'h3FF, 8'h00, 8'h20, 8'h70};
        vecs[3]  = '{1'b1, 1'b1, 11'h005, 8'h41, 8'h41, 8'h00};
        vecs[4]  = '{1'b0, 1'b0, 11'h005, 8'h00, 8'h41, 8'h70};
        vecs[5]  = '{1'b1, 1'b1, 11'h405, 8'h16, 8'h16, 8'h00};
        vecs[6]  = '{1'b0, 1'b0, 11'h005, 8'h00, 8'h41, 8'h16};
        vecs[7]  = '{1'b1, 1'b0, 11'h3FF, 8'h00, 8'h20, 8'h00};
        vecs[8]  = '{1'b1, 1'b0, 11'h005, 8'h00, 8'h41, 8'h00};
        vecs[9]  = '{1'b1, 1'b0, 11'h405, 8'h00, 8'h16, 8'h00};
        vecs[10] = '{1'b0, 1'b0, 11'h006, 8'h00, 8'h20, 8'h70};

        // ---------------- reset state ----------------
        repeat (3) tick();
        chk1("rst_clr_busy", clr_busy, 1'b1);
        chk1("rst_cpu_ack", bus.cpu_ack, 1'b0);
        chk8("rst_vid_data", bus.vid_data, 8'h00);
        chk8("rst_vid_color", bus.vid_color, 8'h00);
        chk8("rst_cpu_dout", bus.cpu_dout, 8'h00);

        // ---------------- clear without strobes ----------------
        reset_n = 1'b1;
        n = 0;
        while (clr_busy === 1'b1 && n < 3000) begin
            n++;
            tick();
        end
        chki("clear_len_idle", n, 1024);
        $display("txn clear length=%0d", n);

        for (int i = 0; i < 1024; i++) begin
            char_m[i]  = 8'h20;
            color_m[i] = 8'h70;
        end

        // ---------------- table vectors ----------------
        for (int i = 0; i < 11; i++) begin
            if (!vecs[i].is_cpu) begin
                vid_read(vecs[i].addr[9:0], d, c);
                $display("txn vec%0d vid addr=%03h data=%02h color=%02h", i, vecs[i].addr, d, c);
                chk8($sformatf("vec%0d_vid_data", i), d, vecs[i].exp_a);
                chk8($sformatf("vec%0d_vid_color", i), c, vecs[i].exp_b);
            end else begin
                cpu_access(vecs[i].we, vecs[i].addr, vecs[i].din, 1'b0, 10'h000, dout, lat, vd, vc);
                $display("txn vec%0d cpu we=%0b addr=%03h dout=%02h lat=%0d",
                         i, vecs[i].we, vecs[i].addr, dout, lat);
                chki($sformatf("vec%0d_lat", i), lat, 1);
                chk8($sformatf("vec%0d_cpu_dout", i), dout, vecs[i].exp_a);
                if (vecs[i].we) begin
                    if (vecs[i].addr[10]) color_m[vecs[i].addr[9:0]] = vecs[i].din;
                    else                  char_m[vecs[i].addr[9:0]]  = vecs[i].din;
                end
                tick();
                chk1($sformatf("vec%0d_ack_pulse", i), bus.cpu_ack, 1'b0);
                chk8($sformatf("vec%0d_dout_hold", i), bus.cpu_dout, vecs[i].exp_a);
            end
        end

        // ---------------- video output holds across CPU traffic ----------------
        cpu_access(1'b1, 11'h006, 8'hAB, 1'b0, 10'h000, dout, lat, vd, vc);
        char_m[6] = 8'hAB;
        $display("txn cpu write addr=006 din=AB lat=%0d", lat);
        tick();
        chk8("vid_hold_data", bus.vid_data, 8'h20);
        chk8("vid_hold_color", bus.vid_color, 8'h70);
        vid_read(10'h006, d, c);
        $display("txn vid addr=006 data=%02h color=%02h", d, c);
        chk8("raw_addr6", d, 8'hAB);

        // ---------------- request collides with a strobe ----------------
        cpu_access(1'b0, 11'h005, 8'h00, 1'b1, 10'h005, dout, lat, vd, vc);
        $display("txn collide cpu read 005 dout=%02h lat=%0d vid=%02h/%02h", dout, lat, vd, vc);
        chki("coll_rd_lat", lat, 2);
        chk8("coll_rd_dout", dout, 8'h41);
        chk8("coll_rd_vdata", vd, 8'h41);
        chk8("coll_rd_vcolor", vc, 8'h16);
        tick();
        cpu_access(1'b1, 11'h007, 8'h5A, 1'b1, 10'h007, dout, lat, vd, vc);
        char_m[7] = 8'h5A;
        $display("txn collide cpu write 007 dout=%02h lat=%0d vid=%02h/%02h", dout, lat, vd, vc);
        chki("coll_wr_lat", lat, 2);
        chk8("coll_wr_vdata_old", vd, 8'h20);
        vid_read(10'h007, d, c);
        chk8("coll_wr_readback", d, 8'h5A);
        chk8("coll_wr_color_kept", c, 8'h70);

        // ---------------- random traffic vs array model ----------------
        for (int k = 0; k < 60; k++) begin
            r  = $urandom;
            r2 = $urandom;
            a  = r[3] ? {6'b000000, r[7:4]} : r[17:8];
            va = r2[0] ? a : r2[10:1];
            collide = (r[29:28] == 2'b00);
            if (r[31:30] == 2'b00) begin
                vid_read(a, d, c);
                $display("txn rnd%0d vid addr=%03h data=%02h color=%02h", k, a, d, c);
                chk8($sformatf("rnd%0d_vid_data", k), d, char_m[a]);
                chk8($sformatf("rnd%0d_vid_color", k), c, color_m[a]);
            end else begin
                ca     = {r[18], a};
                exp_vd = char_m[va];
                exp_vc = color_m[va];
                if (r[30]) exp_d = r[26:19];
                else       exp_d = r[18] ? color_m[a] : char_m[a];
                cpu_access(r[30], ca, r[26:19], collide, va, dout, lat, vd, vc);
                $display("txn rnd%0d cpu we=%0b addr=%03h dout=%02h lat=%0d coll=%0b",
                         k, r[30], ca, dout, lat, collide);
                chki($sformatf("rnd%0d_lat", k), lat, collide ? 2 : 1);
                chk8($sformatf("rnd%0d_cpu_dout", k), dout, exp_d);
                if (collide) begin
                    chk8($sformatf("rnd%0d_coll_vdata", k), vd, exp_vd);
                    chk8($sformatf("rnd%0d_coll_vcolor", k), vc, exp_vc);
                end
                if (r[30]) begin
                    if (r[18]) color_m[a] = r[26:19];
                    else       char_m[a]  = r[26:19];
                end
                tick();
            end
        end

        // ---------------- reset during a CPU access, request held over clear ----------------
        tick();
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b1;
        bus.cpu_addr = 11'h010;
        bus.cpu_din  = 8'h99;
        reset_n      = 1'b0;
        #1;
        chk1("rst2_clr_busy", clr_busy, 1'b1);
        chk1("rst2_cpu_ack", bus.cpu_ack, 1'b0);
        chk8("rst2_cpu_dout", bus.cpu_dout, 8'h00);
        chk8("rst2_vid_data", bus.vid_data, 8'h00);
        chk8("rst2_vid_color", bus.vid_color, 8'h00);
        acks = 0;
        repeat (3) begin
            tick();
            if (bus.cpu_ack === 1'b1) acks++;
        end
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 11'h3FF;
        reset_n      = 1'b1;
        n = 0;
        while (clr_busy === 1'b1 && n < 3000) begin
            if (bus.cpu_ack === 1'b1) acks++;
            n++;
            tick();
        end
        chki("clear_len_req", n, 1024);
        chki("ack_during_clear", acks, 0);
        chk1("ack_first_idle", bus.cpu_ack, 1'b0);
        tick();
        chk1("ack_after_clear", bus.cpu_ack, 1'b1);
        chk8("read_3ff_after_clear", bus.cpu_dout, 8'h20);
        bus.cpu_req = 1'b0;
        $display("txn req-over-clear length=%0d dout=%02h", n, bus.cpu_dout);
        tick();

        // ---------------- reset in the middle of a clear ----------------
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        repeat (300) tick();
        chk1("mid_clear_busy", clr_busy, 1'b1);
        reset_n = 1'b0;
        #1;
        chk1("rst3_clr_busy", clr_busy, 1'b1);
        tick();
        reset_n = 1'b1;

        // ---------------- clear with a strobe every 8th cycle ----------------
        n = 0;
        s = 0;
        while (clr_busy === 1'b1 && n < 3000) begin
            if (n % 8 == 0) begin
                bus.vid_strobe = 1'b1;
                bus.vid_addr   = 10'(n);
                s++;
            end else begin
                bus.vid_strobe = 1'b0;
            end
            n++;
            tick();
        end
        bus.vid_strobe = 1'b0;
        $display("txn strobed clear length=%0d strobes=%0d", n, s);
        chki("clear_len_strobed", n, 1024 + s);

        errs = 0;
        first_bad = -1;
        for (int i = 0; i < 1024; i++) begin
            vid_read(10'(i), d, c);
            if (d !== 8'h20 || c !== 8'h70) begin
                errs++;
                if (first_bad < 0) first_bad = i;
            end
        end
        $display("txn readback sweep locations=1024 wrong=%0d first=%0d", errs, first_bad);
        chki("sweep_wrong_locations", errs, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
